// File: rtl/display_pkg.sv
// Shared constants and helpers for the 7-segment scan controller.
package display_pkg;

  localparam int N_DIGITS = 4;
  localparam int SEG_W    = 7;
  localparam int BRIGHT_W = 4;
  localparam int IDX_W    = $clog2(N_DIGITS);

  localparam logic [SEG_W-1:0]    BLANK_SEG = '1;
  localparam logic [N_DIGITS-1:0] ANODE_OFF = '1;

  // Active-low one-cold anode pattern for the given digit.
  function automatic logic [N_DIGITS-1:0] anode_select(input logic [IDX_W-1:0] idx);
    logic [N_DIGITS-1:0] a;
    a      = ANODE_OFF;
    a[idx] = 1'b0;
    return a;
  endfunction

endpackage

// File: rtl/display_scan_ctrl_if.sv
// Frame-load handshake between the status encoder and the scan controller.
interface display_scan_ctrl_if;
  import display_pkg::*;

  logic [N_DIGITS*SEG_W-1:0] seg_data_flat;
  logic                      load_valid;
  logic                      load_ready;

  modport master (output seg_data_flat, output load_valid, input load_ready);
  modport slave  (input seg_data_flat, input load_valid, output load_ready);

endinterface

// File: rtl/display_scan_ctrl_scan_timer.sv
// Slot timer: t counts through one digit slot, idx steps through the digits.
module scan_timer #(
  parameter int BLANK_CYCLES = 16,
  parameter int STEP_CYCLES  = 62,
  parameter int N_DIGITS     = 4,
  localparam int SLOT_CYCLES = BLANK_CYCLES + 16 * STEP_CYCLES,
  localparam int T_W         = $clog2(SLOT_CYCLES),
  localparam int IDX_W       = $clog2(N_DIGITS)
) (
  input  logic             clk,
  input  logic             rst,
  output logic [T_W-1:0]   t,
  output logic [IDX_W-1:0] idx,
  output logic             boundary
);

  always_ff @(posedge clk) begin
    if (rst) begin
      t   <= '0;
      idx <= '0;
    end else if (t == T_W'(SLOT_CYCLES - 1)) begin
      t   <= '0;
      idx <= (idx == IDX_W'(N_DIGITS - 1)) ? '0 : idx + IDX_W'(1);
    end else begin
      t <= t + T_W'(1);
    end
  end

  assign boundary = (t == '0) && (idx == '0);

endmodule

// File: rtl/display_scan_ctrl.sv
// Double-buffered frame store and digit scanner with dead-time blanking and PWM.
module display_scan_ctrl
  import display_pkg::*;
#(
  parameter int BLANK_CYCLES = 16,
  parameter int STEP_CYCLES  = 62
) (
  input  logic                 clk,
  input  logic                 rst,
  display_scan_ctrl_if.slave   load_if,
  input  logic [N_DIGITS-1:0]  digit_en,
  input  logic [BRIGHT_W-1:0]  brightness,
  output logic [SEG_W-1:0]     segments,
  output logic [N_DIGITS-1:0]  anode,
  output logic [IDX_W-1:0]     digit_idx,
  output logic                 frame_start
);

  localparam int SLOT_CYCLES = BLANK_CYCLES + 16 * STEP_CYCLES;
  localparam int T_W         = $clog2(SLOT_CYCLES);

  logic [T_W-1:0]            t;
  logic [IDX_W-1:0]          idx;
  logic                      boundary;
  logic [N_DIGITS*SEG_W-1:0] pending;
  logic [SEG_W-1:0]          active [N_DIGITS];
  logic                      pending_full;
  logic                      have_frame;
  logic [N_DIGITS-1:0]       en_q;
  logic [BRIGHT_W-1:0]       b_q;
  logic                      accept;
  logic                      lit;
  logic [31:0]               t_ext;
  logic [31:0]               lit_end;

  scan_timer #(
    .BLANK_CYCLES(BLANK_CYCLES),
    .STEP_CYCLES (STEP_CYCLES),
    .N_DIGITS    (N_DIGITS)
  ) u_timer (
    .clk     (clk),
    .rst     (rst),
    .t       (t),
    .idx     (idx),
    .boundary(boundary)
  );

  assign load_if.load_ready = ~pending_full;
  assign accept             = load_if.load_valid && !pending_full;

  assign t_ext   = 32'(t);
  assign lit_end = 32'(BLANK_CYCLES) + (32'(b_q) + 32'd1) * 32'(STEP_CYCLES);
  assign lit     = have_frame && en_q[idx] &&
                   (t_ext >= 32'(BLANK_CYCLES)) && (t_ext < lit_end);

  // Frame storage needs no reset: have_frame and pending_full gate its use.
  always_ff @(posedge clk) begin
    if (accept) begin
      pending <= load_if.seg_data_flat;
    end
    if (boundary && pending_full) begin
      for (int i = 0; i < N_DIGITS; i++) begin
        active[i] <= pending[i*SEG_W +: SEG_W];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pending_full <= 1'b0;
      have_frame   <= 1'b0;
      en_q         <= '0;
      b_q          <= '0;
    end else begin
      if (boundary) begin
        en_q <= digit_en;
        b_q  <= brightness;
      end
      // Accept only happens with pending empty, so it never collides with promotion.
      if (boundary && pending_full) begin
        pending_full <= 1'b0;
        have_frame   <= 1'b1;
      end else if (accept) begin
        pending_full <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      anode       <= ANODE_OFF;
      segments    <= BLANK_SEG;
      digit_idx   <= '0;
      frame_start <= 1'b0;
    end else begin
      anode       <= lit ? anode_select(idx) : ANODE_OFF;
      segments    <= lit ? active[idx] : BLANK_SEG;
      digit_idx   <= idx;
      frame_start <= boundary;
    end
  end

endmodule

// File: tb/tb_display_scan_ctrl.sv
// Directed bench for display_scan_ctrl with a short slot (BLANK=2, STEP=1).
module tb_display_scan_ctrl;
  import display_pkg::*;

  localparam int BLANK = 2;
  localparam int STEP  = 1;
  localparam int SLOT  = 18;
  localparam int FRAME = 72;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] digit_en;
  logic [3:0] brightness;
  logic [6:0] segments;
  logic [3:0] anode;
  logic [1:0] digit_idx;
  logic       frame_start;

  display_scan_ctrl_if load_if();

  display_scan_ctrl #(
    .BLANK_CYCLES(BLANK),
    .STEP_CYCLES (STEP)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .load_if    (load_if),
    .digit_en   (digit_en),
    .brightness (brightness),
    .segments   (segments),
    .anode      (anode),
    .digit_idx  (digit_idx),
    .frame_start(frame_start)
  );

  always #5 clk = ~clk;

  int         checks = 0;
  int         errors = 0;
  int         pos;
  logic       cur_have;
  logic       next_have;
  logic [3:0] cur_en;
  logic [3:0] cur_b;
  logic [6:0] cur_seg  [4];
  logic [6:0] next_seg [4];

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
    end
  endtask

  task automatic applyStimulus(input logic [27:0] flat, input logic valid);
    load_if.seg_data_flat = flat;
    load_if.load_valid    = valid;
  endtask

  // One clock; pos counts edges since reset release, so slot/t follow from it.
  task automatic tick();
    int         t;
    int         idx;
    logic       lit;
    logic [3:0] exp_an;
    logic [6:0] exp_seg;
    @(posedge clk);
    #1;
    pos++;
    if (pos % FRAME == 0) begin
      cur_b    = brightness;
      cur_en   = digit_en;
      cur_have = next_have;
      cur_seg  = next_seg;
    end
    t       = pos % SLOT;
    idx     = (pos / SLOT) % 4;
    lit     = cur_have && cur_en[idx] && (t >= BLANK) && (t < BLANK + (int'(cur_b) + 1) * STEP);
    exp_an  = 4'hF;
    if (lit) exp_an[idx] = 1'b0;
    exp_seg = lit ? cur_seg[idx] : 7'h7F;
    checkOutput($sformatf("anode@%0d", pos), 32'(anode), 32'(exp_an));
    checkOutput($sformatf("segments@%0d", pos), 32'(segments), 32'(exp_seg));
    checkOutput($sformatf("frame_start@%0d", pos), 32'(frame_start), 32'((t == 0) && (idx == 0)));
    checkOutput($sformatf("digit_idx@%0d", pos), 32'(digit_idx), 32'(idx));
  endtask

  task automatic runTo(input int target);
    while (pos < target) tick();
  endtask

  task automatic doReset();
    rst = 1'b1;
    applyStimulus('0, 1'b0);
    @(posedge clk);
    #1;
    checkOutput("rst_anode", 32'(anode), 32'h0F);
    checkOutput("rst_segments", 32'(segments), 32'h7F);
    checkOutput("rst_ready", 32'(load_if.load_ready), 32'h1);
    checkOutput("rst_frame_start", 32'(frame_start), 32'h0);
    checkOutput("rst_digit_idx", 32'(digit_idx), 32'h0);
    rst       = 1'b0;
    pos       = -1;
    cur_have  = 1'b0;
    next_have = 1'b0;
  endtask

  initial begin
    digit_en   = 4'hF;
    brightness = 4'd15;
    rst        = 1'b1;
    applyStimulus('0, 1'b0);
    for (int i = 0; i < 4; i++) begin
      cur_seg[i]  = 7'h7F;
      next_seg[i] = 7'h7F;
    end
    doReset();

    // Idle: dark, frame_start every 72 cycles
    runTo(299);
    checkOutput("ready_idle", 32'(load_if.load_ready), 32'h1);

    // First frame, full brightness
    applyStimulus({7'h79, 7'h6D, 7'h30, 7'h7E}, 1'b1);
    tick();
    checkOutput("ready_after_load", 32'(load_if.load_ready), 32'h0);
    applyStimulus('0, 1'b0);
    next_seg  = '{7'h7E, 7'h30, 7'h6D, 7'h79};
    next_have = 1'b1;
    runTo(359);
    checkOutput("ready_before_boundary", 32'(load_if.load_ready), 32'h0);
    tick();
    checkOutput("ready_at_boundary", 32'(load_if.load_ready), 32'h1);
    runTo(361);
    checkOutput("s0_blank_t1", 32'(anode), 32'h0F);
    tick();
    checkOutput("s0_anode", 32'(anode), 32'b1110);
    checkOutput("s0_seg", 32'(segments), 32'h7E);
    runTo(380);
    checkOutput("s1_anode", 32'(anode), 32'b1101);
    checkOutput("s1_seg", 32'(segments), 32'h30);
    runTo(398);
    checkOutput("s2_anode", 32'(anode), 32'b1011);
    checkOutput("s2_seg", 32'(segments), 32'h6D);
    runTo(416);
    checkOutput("s3_anode", 32'(anode), 32'b0111);
    checkOutput("s3_seg", 32'(segments), 32'h79);

    // Brightness 3, then a mid-frame change that must wait for the next frame
    runTo(431);
    brightness = 4'd3;
    runTo(437);
    checkOutput("b3_last_lit", 32'(anode), 32'b1110);
    tick();
    checkOutput("b3_first_dark", 32'(anode), 32'h0F);
    runTo(450);
    brightness = 4'd9;
    runTo(455);
    checkOutput("b3_hold_lit", 32'(anode), 32'b1101);
    tick();
    checkOutput("b3_hold_dark", 32'(anode), 32'h0F);
    runTo(515);
    checkOutput("b9_last_lit", 32'(anode), 32'b1110);
    tick();
    checkOutput("b9_first_dark", 32'(anode), 32'h0F);

    // Digit enable 0101
    runTo(575);
    digit_en = 4'b0101;
    runTo(578);
    checkOutput("en_digit0_lit", 32'(anode), 32'b1110);
    runTo(596);
    checkOutput("en_digit1_dark", 32'(anode), 32'h0F);
    runTo(647);

    // Back-to-back offers; A accepted in the boundary cycle
    digit_en   = 4'hF;
    brightness = 4'd15;
    applyStimulus({7'h44, 7'h33, 7'h22, 7'h11}, 1'b1);
    tick();
    checkOutput("ready_after_A", 32'(load_if.load_ready), 32'h0);
    next_seg  = '{7'h11, 7'h22, 7'h33, 7'h44};
    next_have = 1'b1;
    applyStimulus({7'h0F, 7'h1E, 7'h2D, 7'h3C}, 1'b1);
    runTo(650);
    checkOutput("A_not_bypassed", 32'(segments), 32'h7E);
    runTo(719);
    checkOutput("B_held", 32'(load_if.load_ready), 32'h0);
    tick();
    checkOutput("ready_rises", 32'(load_if.load_ready), 32'h1);
    tick();
    checkOutput("ready_after_B", 32'(load_if.load_ready), 32'h0);
    applyStimulus('0, 1'b0);
    next_seg = '{7'h3C, 7'h2D, 7'h1E, 7'h0F};
    runTo(722);
    checkOutput("A_active", 32'(segments), 32'h11);
    runTo(794);
    checkOutput("B_active", 32'(segments), 32'h3C);

    // Reset while lit with a frame pending; both buffers must be lost
    runTo(866);
    applyStimulus({7'h55, 7'h55, 7'h55, 7'h55}, 1'b1);
    tick();
    checkOutput("ready_after_D", 32'(load_if.load_ready), 32'h0);
    applyStimulus('0, 1'b0);
    runTo(870);
    checkOutput("lit_before_reset", 32'(anode), 32'b1110);
    doReset();
    runTo(150);
    checkOutput("ready_after_reset", 32'(load_if.load_ready), 32'h1);
    applyStimulus({7'h08, 7'h04, 7'h02, 7'h01}, 1'b1);
    tick();
    applyStimulus('0, 1'b0);
    next_seg  = '{7'h01, 7'h02, 7'h04, 7'h08};
    next_have = 1'b1;
    runTo(218);
    checkOutput("reload_anode", 32'(anode), 32'b1110);
    checkOutput("reload_seg", 32'(segments), 32'h01);
    runTo(290);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/display_scan_ctrl.md
Name: display_scan_ctrl

Overview:
Sequencer and frame buffer for a common-anode 4-digit 7-segment display. It double-buffers segment frames loaded through a valid/ready handshake and scans the digits with a fixed slot time. Each slot starts with a dead-time blank interval to suppress ghosting. PWM brightness control and per-digit enable are applied on top. It sits between the traffic-light status/encoder logic and the board's segment and anode pins, and owns all digit timing.

Parameters:
N_DIGITS, 4, number of digits scanned (anode width).
SEG_W, 7, segment bits per digit (a-g).
BLANK_CYCLES, 16, all-anodes-off cycles at the start of every slot (≥1).
STEP_CYCLES, 62, cycles per brightness step; SLOT_CYCLES = BLANK_CYCLES + 16*STEP_CYCLES.

Ports:
clk  in  1  system clock
rst  in  1  synchronous active-high reset
seg_data_flat  in  N_DIGITS*SEG_W  frame to load; digit i at [i*SEG_W +: SEG_W]; active-low segment encoding
load_valid  in  1  frame offered on seg_data_flat
load_ready  out  1  pending buffer empty; frame accepted when load_valid && load_ready
digit_en  in  N_DIGITS  per-digit enable, sampled at frame boundary
brightness  in  4  0..15, sampled at frame boundary
segments  out  SEG_W  active-low segment drive, registered
anode  out  N_DIGITS  active-low digit select, registered, at most one bit low
digit_idx  out  2  index of current slot, registered
frame_start  out  1  one-cycle pulse aligned with slot 0 / t=0 outputs

Behaviour:
- One clock domain (clk). Reset is synchronous and active-high (rst). All state updates on posedge clk.
- Reset values: anode all 1s, segments all 1s, digit_idx 0, frame_start 0, load_ready 1, pending_full 0, have_frame 0, slot counter t=0.
- Timer: t counts 0..SLOT_CYCLES-1 and then wraps to 0. At the wrap, idx increments and wraps from N_DIGITS-1 to 0.
- Frame boundary: the cycle where idx==0 and t==0. The first boundary is the first cycle after rst deasserts.
- Handshake: load_ready = !pending_full. On accept, the pending buffer captures seg_data_flat and pending_full is set. Offers made while load_ready is 0 are ignored, and the source must hold them.
- At a boundary, if pending_full: active <= pending, pending_full cleared, have_frame set. digit_en and brightness are latched into en_q and b_q on every boundary.
- Accept and boundary in the same cycle: data goes to pending and becomes active at the next boundary. This is one frame of latency, and no bypass is allowed.
- Lit condition for slot idx: have_frame && en_q[idx] && BLANK_CYCLES ≤ t < BLANK_CYCLES + (b_q+1)*STEP_CYCLES.
- Lit drive: anode = ~(1<<idx) and segments = active[idx].
- Unlit drive: anode all 1s and segments all 1s.
- b_q=15 lights the whole post-blank window. b_q=0 lights for STEP_CYCLES cycles.
- Disabled digits still consume their slot, so the frame period stays fixed at N_DIGITS*SLOT_CYCLES.
- Outputs (anode, segments, digit_idx, frame_start) are registered. They reflect the counter state of the previous cycle, giving a latency of 1 cycle.
- Reset mid-operation: outputs return to their reset values next cycle. Both buffers are invalidated, and the display stays dark until a new frame is loaded and a boundary passes.
- brightness or digit_en changing mid-frame has no effect until the next boundary.

Decomposition:
- Package display_pkg holds:
  - N_DIGITS, SEG_W, and BLANK_SEG (all 1s).
  - ANODE_OFF (all 1s).
  - The 4-bit brightness width.
- Sub-module scan_timer (parameters BLANK_CYCLES, STEP_CYCLES, N_DIGITS) owns t, idx and the boundary pulse.
- The top level holds the buffers, the handshake and the output registers.

Test Plan:
(All scenarios use BLANK_CYCLES=2, STEP_CYCLES=1, so SLOT=18 and the frame is 72 cycles.)
1. Reset, no load for 300 cycles -> anode stays 4'b1111, segments 7'h7F, load_ready=1, frame_start pulses every 72 cycles.
2. Load 0x7E,0x30,0x6D,0x79 (digits 0-3) with brightness=15 and all enabled -> at the next boundary, per slot: 2 cycles with anode 1111, then 16 cycles with anode 1110 and segments 0x7E. The sequence continues 1101/0x30, 1011/0x6D, 0111/0x79.
3. brightness=3 latched -> each slot shows 2 blank cycles, 4 lit cycles, then 12 dark cycles. A brightness change mid-frame applies only from the next frame_start.
4. digit_en=4'b0101 -> anode never equals 1101 or 0111, and the period between frame_start pulses remains 72.
5. Two back-to-back offers A then B -> A accepted and load_ready drops. B is held until the boundary, where A goes active and load_ready rises. B is accepted and goes active one frame later. An accept in the boundary cycle also delays activation by one frame.
6. Assert rst for 1 cycle mid-slot while lit -> next cycle anode 1111, load_ready 1. The display stays dark across later boundaries until a reload is done.
